// File: rtl/bp_mem_arbiter_pkg.sv
// bp_mem_arbiter_pkg: shared helpers for the CCE memory-port arbiter
package bp_mem_arbiter_pkg;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bp_mem_arbiter_channel.sv
// bp_mem_arbiter_channel: round-robin issue of N requests to one port, in-order response return via an ID FIFO
module bp_mem_arbiter_channel
  import bp_mem_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int lg_num_req_p = safe_clog2(num_req_p),
  parameter int req_width_p = 128,
  parameter int resp_width_p = 128,
  parameter int depth_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p*req_width_p-1:0]  req_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_yumi_o,
  output logic [req_width_p-1:0]            mem_o,
  output logic                              mem_v_o,
  input  logic                              mem_yumi_i,
  input  logic [resp_width_p-1:0]           mem_resp_i,
  input  logic                              mem_resp_v_i,
  output logic                              mem_resp_ready_o,
  output logic [num_req_p*resp_width_p-1:0] resp_o,
  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_ready_i
);
  localparam int lg_depth_lp = safe_clog2(depth_p);
  localparam int cnt_w_lp = $clog2(depth_p + 1);
  logic [lg_num_req_p-1:0] ptr, winner, cand, head;
  logic [lg_num_req_p-1:0] ids [depth_p];
  logic [lg_depth_lp-1:0] rd, wr;
  logic [cnt_w_lp-1:0] count;
  logic full, empty, push, pop;
  // Scan downward so the valid requester closest to the pointer is written last and wins.
  always_comb begin
    winner = ptr;
    cand = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = lg_num_req_p'((int'(ptr) + i) % num_req_p);
      if (req_v_i[cand]) winner = cand;
    end
  end
  assign full = count == cnt_w_lp'(depth_p);
  assign empty = count == '0;
  assign head = ids[rd];
  assign mem_v_o = ~reset_i & (|req_v_i) & ~full;
  assign push = mem_v_o & mem_yumi_i;
  assign req_yumi_o = push ? num_req_p'(1) << winner : '0;
  assign mem_o = req_i[winner*req_width_p +: req_width_p];
  assign resp_o = {num_req_p{mem_resp_i}};
  assign resp_v_o = (~reset_i & mem_resp_v_i & ~empty) ? num_req_p'(1) << head : '0;
  assign mem_resp_ready_o = ~reset_i & ~empty & resp_ready_i[head];
  assign pop = mem_resp_v_i & mem_resp_ready_o;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      ptr <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ptr <= (winner == lg_num_req_p'(num_req_p - 1)) ? '0 : winner + 1'b1;
        wr <= (wr == lg_depth_lp'(depth_p - 1)) ? '0 : wr + 1'b1;
      end
      if (pop) rd <= (rd == lg_depth_lp'(depth_p - 1)) ? '0 : rd + 1'b1;
      count <= count + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) ids[wr] <= winner;
  always_ff @(posedge clk_i)
    if (!reset_i && mem_resp_v_i) assert (!empty) else $error("response arrived with no outstanding request");
endmodule

// File: rtl/bp_mem_arbiter.sv
// bp_mem_arbiter: shares one memory port between CCEs with independent read and writeback channels
module bp_mem_arbiter
  import bp_mem_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int cmd_width_p = 128,
  parameter int data_cmd_width_p = 640,
  parameter int resp_width_p = 128,
  parameter int data_resp_width_p = 640,
  parameter int max_outstanding_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p*cmd_width_p-1:0]       req_cmd_i,
  input  logic [num_req_p-1:0]                   req_cmd_v_i,
  output logic [num_req_p-1:0]                   req_cmd_yumi_o,
  input  logic [num_req_p*data_cmd_width_p-1:0]  req_data_cmd_i,
  input  logic [num_req_p-1:0]                   req_data_cmd_v_i,
  output logic [num_req_p-1:0]                   req_data_cmd_yumi_o,
  output logic [num_req_p*data_resp_width_p-1:0] req_data_resp_o,
  output logic [num_req_p-1:0]                   req_data_resp_v_o,
  input  logic [num_req_p-1:0]                   req_data_resp_ready_i,
  output logic [num_req_p*resp_width_p-1:0]      req_resp_o,
  output logic [num_req_p-1:0]                   req_resp_v_o,
  input  logic [num_req_p-1:0]                   req_resp_ready_i,
  output logic [cmd_width_p-1:0]                 mem_cmd_o,
  output logic                                   mem_cmd_v_o,
  input  logic                                   mem_cmd_yumi_i,
  output logic [data_cmd_width_p-1:0]            mem_data_cmd_o,
  output logic                                   mem_data_cmd_v_o,
  input  logic                                   mem_data_cmd_yumi_i,
  input  logic [data_resp_width_p-1:0]           mem_data_resp_i,
  input  logic                                   mem_data_resp_v_i,
  output logic                                   mem_data_resp_ready_o,
  input  logic [resp_width_p-1:0]                mem_resp_i,
  input  logic                                   mem_resp_v_i,
  output logic                                   mem_resp_ready_o
);
  localparam int lg_num_req_lp = safe_clog2(num_req_p);
  bp_mem_arbiter_channel #(
    .num_req_p(num_req_p), .lg_num_req_p(lg_num_req_lp), .req_width_p(cmd_width_p),
    .resp_width_p(data_resp_width_p), .depth_p(max_outstanding_p)
  ) rd_chan (
    .clk_i, .reset_i,
    .req_i(req_cmd_i), .req_v_i(req_cmd_v_i), .req_yumi_o(req_cmd_yumi_o),
    .mem_o(mem_cmd_o), .mem_v_o(mem_cmd_v_o), .mem_yumi_i(mem_cmd_yumi_i),
    .mem_resp_i(mem_data_resp_i), .mem_resp_v_i(mem_data_resp_v_i), .mem_resp_ready_o(mem_data_resp_ready_o),
    .resp_o(req_data_resp_o), .resp_v_o(req_data_resp_v_o), .resp_ready_i(req_data_resp_ready_i)
  );
  bp_mem_arbiter_channel #(
    .num_req_p(num_req_p), .lg_num_req_p(lg_num_req_lp), .req_width_p(data_cmd_width_p),
    .resp_width_p(resp_width_p), .depth_p(max_outstanding_p)
  ) wb_chan (
    .clk_i, .reset_i,
    .req_i(req_data_cmd_i), .req_v_i(req_data_cmd_v_i), .req_yumi_o(req_data_cmd_yumi_o),
    .mem_o(mem_data_cmd_o), .mem_v_o(mem_data_cmd_v_o), .mem_yumi_i(mem_data_cmd_yumi_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
    .resp_o(req_resp_o), .resp_v_o(req_resp_v_o), .resp_ready_i(req_resp_ready_i)
  );
endmodule
